// File: rtl/traffic_inject_ctrl_if.sv
// Flit handshake between the injection controller and a router input port.
interface traffic_inject_ctrl_if;
    logic [15:0] flit_out;
    logic        flit_valid;
    logic        flit_ready;

    modport master (output flit_out, flit_valid, input flit_ready);
    modport slave  (input flit_out, flit_valid, output flit_ready);
endinterface

// File: rtl/traffic_inject_ctrl.sv
// LFSR-driven injection controller: samples an external LFSR against RATE and
// emits fixed-length packets of 16-bit flits over a valid/ready handshake.
module traffic_inject_ctrl #(
    parameter int unsigned PKT_LEN = 4,
    parameter logic [7:0]  RATE    = 8'd64,
    parameter logic [2:0]  SRC_ID  = 3'd0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          lfsr_en,
    input  logic [7:0]                    lfsr_val,
    traffic_inject_ctrl_if.master         flit,
    output logic [15:0]                   pkt_count,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, SAMPLE, SEND} state_t;

    localparam logic [3:0] LAST = 4'(PKT_LEN - 1);

    state_t      state, state_next;
    logic [2:0]  dest, dest_next;
    logic [3:0]  idx, idx_next;
    logic [15:0] cnt_next;
    logic [15:0] flit_word;

    function automatic logic [1:0] flit_type(input logic [3:0] i);
        if (PKT_LEN == 1)   return 2'b11;
        else if (i == 4'd0) return 2'b01;
        else if (i == LAST) return 2'b10;
        else                return 2'b00;
    endfunction

    assign lfsr_en = (state == SAMPLE);

    always_comb begin
        state_next = state;
        dest_next  = dest;
        idx_next   = idx;
        cnt_next   = pkt_count;
        case (state)
            IDLE: begin
                if (start) state_next = SAMPLE;
            end
            SAMPLE: begin
                if (lfsr_val < RATE) begin
                    dest_next  = lfsr_val[2:0];
                    idx_next   = '0;
                    state_next = SEND;
                end else if (!start) begin
                    state_next = IDLE;
                end
            end
            SEND: begin
                if (flit.flit_valid && flit.flit_ready) begin
                    if (idx == LAST) begin
                        cnt_next   = pkt_count + 16'd1;
                        state_next = start ? SAMPLE : IDLE;
                    end else begin
                        idx_next = idx + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Flit word is built from next-state values so flit_out is a plain register.
    assign flit_word = {flit_type(idx_next), dest_next, SRC_ID, cnt_next[3:0], idx_next};

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            dest            <= '0;
            idx             <= '0;
            pkt_count       <= '0;
            busy            <= 1'b0;
            flit.flit_valid <= 1'b0;
            flit.flit_out   <= '0;
        end else begin
            state           <= state_next;
            dest            <= dest_next;
            idx             <= idx_next;
            pkt_count       <= cnt_next;
            busy            <= (state_next != IDLE);
            flit.flit_valid <= (state_next == SEND);
            if (state_next == SEND) flit.flit_out <= flit_word;
        end
    end

endmodule

// File: tb/tb_traffic_inject_ctrl.sv
// Bench for traffic_inject_ctrl: four parameter sets share stimulus; each has
// its own LFSR, reference model, flit scoreboard and cycle-rule monitor.
module tb_traffic_inject_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       ready_all = 1'b1;
    logic [3:0] do_preload = '0;
    logic       end_req = 1'b0;
    logic [3:0] busy_w;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: actual %0h required %0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timeout waiting for DUT at %0t", name, $time);
    endtask

    function automatic logic [1:0] ftype(input int unsigned j, input int unsigned len);
        if (len == 1)            return 2'b11;
        else if (j == 0)         return 2'b01;
        else if (j == len - 1)   return 2'b10;
        else                     return 2'b00;
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_inst
        localparam int unsigned P_LEN  = (gi == 2) ? 1 : (gi == 3) ? 3 : 4;
        localparam logic [7:0]  P_RATE = (gi == 0) ? 8'd4 : (gi == 1) ? 8'd0 : (gi == 2) ? 8'd255 : 8'd100;
        localparam logic [2:0]  P_SRC  = (gi == 0) ? 3'd0 : (gi == 1) ? 3'd5 : (gi == 2) ? 3'd2 : 3'd7;

        traffic_inject_ctrl_if u_if ();
        logic        lfsr_en;
        logic [7:0]  lfsr;
        logic [15:0] pkt_count;
        logic        busy;

        assign u_if.flit_ready = ready_all;
        assign busy_w[gi] = busy;

        traffic_inject_ctrl #(.PKT_LEN(P_LEN), .RATE(P_RATE), .SRC_ID(P_SRC)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start),
            .lfsr_en   (lfsr_en),
            .lfsr_val  (lfsr),
            .flit      (u_if.master),
            .pkt_count (pkt_count),
            .busy      (busy)
        );

        // Team LFSR: reset 0, XNOR taps 7,3,2,1
        always_ff @(posedge clk) begin
            if (reset)        lfsr <= 8'h00;
            else if (lfsr_en) lfsr <= {lfsr[6:0], ~(lfsr[7] ^ lfsr[3] ^ lfsr[2] ^ lfsr[1])};
        end

        logic [15:0] q[$];
        logic [15:0] m_count = '0;
        logic [15:0] held = '0;
        logic [15:0] e;
        logic [15:0] heads[8];
        bit          held_v = 0;
        bit          exp_rst = 0;
        int          exp_mode = 0; // 0 none, 1 idle, 2 sample, 3 send
        int          n_acc = 0;
        int          n_heads = 0;

        always @(negedge clk) begin
            if (do_preload[gi]) m_count = 16'hFFFF;
            if (exp_mode == 1) begin
                check("idle_valid", gi, u_if.flit_valid, 1'b0);
                check("idle_lfsr_en", gi, lfsr_en, 1'b0);
                check("idle_busy", gi, busy, 1'b0);
            end else if (exp_mode == 2) begin
                check("sample_lfsr_en", gi, lfsr_en, 1'b1);
                check("sample_valid", gi, u_if.flit_valid, 1'b0);
                check("sample_busy", gi, busy, 1'b1);
            end else if (exp_mode == 3) begin
                check("send_valid", gi, u_if.flit_valid, 1'b1);
                check("send_lfsr_en", gi, lfsr_en, 1'b0);
                check("send_busy", gi, busy, 1'b1);
            end
            if (exp_rst) check("reset_flit_out", gi, u_if.flit_out, 16'h0000);
            if (exp_mode != 0) check("pkt_count", gi, pkt_count, m_count);
            if (held_v && u_if.flit_valid) check("hold_stable", gi, u_if.flit_out, held);
            if (end_req) check("queue_empty", gi, q.size(), 0);
            held_v = 0;

            if (reset) begin
                q.delete();
                m_count  = '0;
                exp_mode = 1;
                exp_rst  = 1;
            end else begin
                exp_rst = 0;
                if (lfsr_en) begin
                    if (lfsr < P_RATE) begin
                        for (int unsigned j = 0; j < P_LEN; j++)
                            q.push_back({ftype(j, P_LEN), lfsr[2:0], P_SRC, m_count[3:0], 4'(j)});
                        exp_mode = 3;
                    end else begin
                        exp_mode = start ? 2 : 1;
                    end
                end else if (u_if.flit_valid) begin
                    if (q.size() == 0) begin
                        fail_timeout("unexpected_flit");
                        exp_mode = 0;
                    end else if (ready_all) begin
                        e = q.pop_front();
                        check("flit", gi, u_if.flit_out, e);
                        n_acc++;
                        if (e[3:0] == 4'd0) begin
                            if (n_heads < 8) heads[n_heads] = u_if.flit_out;
                            n_heads++;
                        end
                        if (32'(e[3:0]) == P_LEN - 1) begin
                            m_count++;
                            exp_mode = start ? 2 : 1;
                        end else begin
                            exp_mode = 3;
                        end
                    end else begin
                        held     = u_if.flit_out;
                        held_v   = 1;
                        exp_mode = 3;
                    end
                end else begin
                    exp_mode = start ? 2 : 1;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy_w != 4'b0 && t < 100) begin step(1); t++; end
        if (t >= 100) fail_timeout(name);
    endtask

    task automatic pulse_end_check();
        end_req = 1'b1;
        step(1);
        end_req = 1'b0;
    endtask

    initial begin
        int t;
        int base;

        // LFSR-driven injection: samples 00,01,03 hit -> three packets
        step(3);
        reset = 1'b0;
        start = 1'b1;
        t = 0;
        while (g_inst[0].pkt_count != 16'd3 && t < 200) begin step(1); t++; end
        if (t >= 200) fail_timeout("lfsr_three_packets");
        start = 1'b0;
        step(5);
        check("n_heads", 0, 32'(g_inst[0].n_heads), 32'd3);
        check("head0", 0, g_inst[0].heads[0], 16'h4000);
        check("head1", 0, g_inst[0].heads[1], 16'h4810);
        check("head2", 0, g_inst[0].heads[2], 16'h5820);
        check("count3", 0, g_inst[0].pkt_count, 16'd3);
        wait_idle("idle_after_lfsr");

        // Backpressure on the head flit for 5 cycles
        do_reset();
        base = g_inst[0].n_acc;
        start = 1'b1;
        ready_all = 1'b0;
        step(7);
        check("bp_head_valid", 0, g_inst[0].u_if.flit_valid, 1'b1);
        check("bp_head_word", 0, g_inst[0].u_if.flit_out, 16'h4000);
        ready_all = 1'b1;
        step(4);
        check("bp_accepts", 0, 32'(g_inst[0].n_acc - base), 32'd4);
        check("bp_count", 0, g_inst[0].pkt_count, 16'd1);
        start = 1'b0;
        step(10);
        wait_idle("idle_after_bp");

        // Start dropped after the 2nd flit
        do_reset();
        base = g_inst[0].n_acc;
        start = 1'b1;
        t = 0;
        while (g_inst[0].n_acc - base < 2 && t < 50) begin step(1); t++; end
        if (t >= 50) fail_timeout("drop_two_flits");
        start = 1'b0;
        wait_idle("idle_after_drop");
        check("drop_accepts", 0, 32'(g_inst[0].n_acc - base), 32'd4);
        check("drop_count", 0, g_inst[0].pkt_count, 16'd1);
        step(10);

        // Reset during flit 2, then restart
        do_reset();
        base = g_inst[0].n_acc;
        start = 1'b1;
        t = 0;
        while (g_inst[0].n_acc - base < 1 && t < 50) begin step(1); t++; end
        if (t >= 50) fail_timeout("reset_mid_first_flit");
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        base = g_inst[0].n_heads;
        step(30);
        check("restart_head", 0, g_inst[0].heads[base % 8], 16'h4000);
        start = 1'b0;
        wait_idle("idle_after_reset_mid");

        // Randomised start / ready / occasional reset
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 9) != 0);
            ready_all = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 499) == 0);
            step(1);
        end
        reset = 1'b0;
        start = 1'b0;
        ready_all = 1'b1;
        wait_idle("idle_after_random");
        pulse_end_check();

        // pkt_count wrap from a forced 0xFFFF
        do_reset();
        step(2);
        force g_inst[0].u_dut.pkt_count = 16'hFFFF;
        do_preload = 4'b0001;
        step(1);
        release g_inst[0].u_dut.pkt_count;
        do_preload = '0;
        step(1);
        base = g_inst[0].n_acc;
        start = 1'b1;
        t = 0;
        while (g_inst[0].n_acc - base < 4 && t < 50) begin step(1); t++; end
        if (t >= 50) fail_timeout("wrap_packet");
        check("wrap_count", 0, g_inst[0].pkt_count, 16'h0000);
        start = 1'b0;
        wait_idle("idle_after_wrap");
        pulse_end_check();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/traffic_inject_ctrl.md
# traffic_inject_ctrl

Injection controller for the router's pseudo-random traffic generator. It steps an external 8-bit LFSR, compares each sample against a programmable injection-rate threshold, and on a hit emits a fixed-length packet of 16-bit flits to a router input port over a valid/ready handshake. It sits between the LFSR traffic source and the local injection port of a router, and counts injected packets for the bench.

## Interface
- PKT_LEN, 4: flits per packet, legal 1..15.
- RATE, 8'd64: injection threshold; a sample `lfsr_val < RATE` starts a packet.
- SRC_ID, 3'd0: source node ID inserted in every flit.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  level enable; high = generate traffic.
- lfsr_en  out  1  advance strobe to the LFSR.
- lfsr_val  in  8  current LFSR value.
- flit_out  out  16  flit data.
- flit_valid  out  1  flit_out is valid.
- flit_ready  in  1  router accepts the flit this cycle.
- pkt_count  out  16  completed packets, wraps.
- busy  out  1  high in SAMPLE or SEND.

## Operation
- Flit format: [15:14] type (01 head, 00 body, 10 tail, 11 single-flit); [13:11] dest; [10:8] SRC_ID; [7:4] pkt_count[3:0]; [3:0] flit index.
- FSM states: IDLE, SAMPLE, SEND.
- IDLE: lfsr_en=0, flit_valid=0. If start=1, go to SAMPLE.
- SAMPLE: lfsr_en=1, so the LFSR advances at the closing edge. The controller compares the lfsr_val present this cycle.
  - Hit (`lfsr_val < RATE`): latch dest=lfsr_val[2:0], clear flit index, go to SEND.
  - Miss with start=1: stay in SAMPLE. This is a gap cycle.
  - Miss with start=0: go to IDLE.
- SEND: lfsr_en=0, flit_valid=1. flit_out holds stable until flit_ready=1.
  - On accept with index < PKT_LEN-1: increment the index.
  - On accept with index == PKT_LEN-1: increment pkt_count. Go to SAMPLE if start=1, else IDLE.
- Type encoding: index 0 → head, index PKT_LEN-1 → tail, otherwise body. PKT_LEN=1 → type 11.
- Deasserting start mid-packet does not truncate the packet. The current packet completes, then the FSM goes to IDLE.
- RATE=0: the controller never injects and stays in SAMPLE while start=1. RATE=255: every sample hits, because the XNOR LFSR from reset never reaches 0xFF.
- pkt_count wraps from 0xFFFF to 0x0000.
- busy = (state != IDLE).

## Timing
- Reset values:
  - state=IDLE
  - lfsr_en=0
  - flit_valid=0
  - flit_out=16'h0000
  - pkt_count=0
  - busy=0
  - internal dest and index = 0
- Reset mid-packet: flit_valid drops at the next edge. The partial packet is abandoned, with no tail.
- Output registers: flit_valid, busy and flit_out come from registers only. No combinational path exists from flit_ready or lfsr_val to any output.
- lfsr_en depends only on state.
- Start latency: start rises before edge 0 → SAMPLE during cycle 1. On a hit, the head flit is valid in cycle 2.
- Per-packet cost: PKT_LEN accept cycles plus at least 1 SAMPLE cycle. Back-to-back packets have exactly one non-valid cycle between the tail and the next head.
- Handshake: a flit transfers on an edge where flit_valid & flit_ready = 1. If flit_ready=0, the flit is held with no change.
- LFSR advance: the LFSR advances exactly once per SAMPLE cycle and never in SEND or IDLE.

## Test plan
- LFSR-driven injection: reset, then connect the team LFSR (reset 0, XNOR taps 7,3,2,1) with RATE=4, PKT_LEN=4, start=1. Samples run 0x00 hit → 0x01 hit → 0x03 hit → 0x06 miss → 0x0D miss. Required: three packets with dest 0, 1, 3. Head flits read 16'h4000, 16'h4810, 16'h5820. pkt_count=3.
- Backpressure: hold flit_ready=0 for 5 cycles on the head flit, then release. Required: flit_out stable and flit_valid=1 throughout, the LFSR does not advance, and all 4 flits are then delivered in order (types 01, 00, 00, 10).
- Start dropped mid-packet: deassert start after the 2nd flit is accepted. Required: flits 3 and 4 are still sent, pkt_count increments, then IDLE with busy=0 and no further lfsr_en pulses.
- Reset mid-packet: assert reset during flit 2. Required: the next cycle shows flit_valid=0, pkt_count=0, lfsr_en=0. The sequence restarts from the head after reset is released.
- Boundaries:
  - RATE=0: lfsr_en is high every cycle and flit_valid is never asserted.
  - PKT_LEN=1: every flit has type 11.
  - Preload pkt_count=0xFFFF via a force: wraps to 0x0000 after the next packet.
